xorexec_host: RTL and testbench
===============================

Name: xorexec_host

Overview:
Host-side traffic engine for the xorexec datapath, sitting on the opposite end of its two FIFO interfaces. It generates a programmable-length byte stream into the input FIFO (push only when not_full) and drains the output FIFO (pop when rdy). It accumulates XOR signatures and counts on both streams, and flags a stall timeout. It is used as a bring-up stimulus and self-check engine on the bench and in system builds.

Parameters:
dwidth, 8, data width of both FIFO interfaces (the LFSR is defined for 8).
timeout, 64, cycles with no ofifo pop while receive is outstanding before error; minimum 2.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
len  input  8  number of bytes to send and expect back; sampled with start
seed  input  8  LFSR seed, sampled with start; 8'h00 is replaced by 8'h01
ififo_push  output  1  push to input FIFO
ififo_not_full  input  1  input FIFO can accept
idata  output  dwidth  data to input FIFO
ofifo_pop  output  1  pop from output FIFO
ofifo_rdy  input  1  output FIFO has data
odata  input  dwidth  output FIFO head data
busy  output  1  run in progress (RUN state)
done  output  1  one-cycle pulse at end of run (normal or error)
err  output  1  sticky timeout flag; cleared by next accepted start or rst
tx_count  output  8  bytes pushed this run
rx_count  output  8  bytes popped this run
tx_xor  output  dwidth  XOR of all pushed bytes this run
rx_xor  output  dwidth  XOR of all popped bytes this run

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE. ififo_push=0, ofifo_pop=0, busy=0, done=0, err=0. Counts, XORs, and the timeout counter are 0. LFSR=8'h01, so idata=8'h01.
- States: IDLE, RUN, FIN.
- IDLE + start with len!=0: go to RUN. Load LFSR with seed (0 is replaced by 1). Clear counts, XORs, err, and the timeout counter.
- IDLE + start with len==0: go to FIN. Clear err, counts, and XORs. No traffic.
- RUN:
  - ififo_push = not_full && (tx_count<len), combinational. idata = current LFSR value.
  - On push: tx_count++, tx_xor^=idata, LFSR advances.
  - LFSR next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - ofifo_pop = rdy && (rx_count<len), combinational. On pop: rx_count++, rx_xor^=odata.
  - Push and pop may occur in the same cycle; they are independent.
- Timeout counter: clears on any pop. Otherwise it increments while rx_count<len in RUN. When it reaches timeout-1 without a pop: err=1, go to FIN.
- RUN -> FIN when tx_count==len and rx_count==len. Check this on registered values, so FIN follows the final pop by exactly one cycle.
- FIN: done=1 for one cycle, busy=0, then go to IDLE. Counts, XORs, and err hold until the next accepted start.
- busy=1 exactly in RUN. start is ignored outside IDLE.
- Outside RUN: ififo_push=0 and ofifo_pop=0.
- Counts are 8-bit with no wrap, since they are bounded by len≤255.
- rst in any state returns to reset values next cycle. An in-flight push or pop in that same cycle is still taken by the FIFOs; the host does not re-count it.
- Extra ofifo data beyond len is left unpopped.

Decomposition:
- Package xorexec_pkg holds:
  - state enum {IDLE,RUN,FIN};
  - LFSR tap constant;
  - default-seed constant 8'h01.
- One natural sub-module, lfsr8: load, advance enable, and 8-bit state output. Everything else is inline.

Test Plan:
- Loopback, seed=8'h01, len=4, not_full=1, ofifo fed back in order → idata 01,02,04,08 on 4 consecutive cycles; tx_xor=rx_xor=8'h0F; done pulse; tx_count=rx_count=4; err=0.
- not_full low on cycles 2–4 of a run → no push while low; sequence resumes without skipping values; push never asserted with not_full=0.
- start with len=0 → done the next cycle, busy never 1, no push or pop, counts 0.
- seed=8'h00, len=2 → first two bytes 01,02 (zero-seed substitution).
- timeout=8, len=3, ofifo_rdy held 0 → err=1 and done pulse after 8 cycles in RUN. A following start with len=1 clears err.
- rst asserted mid-run after 2 pushes → next cycle IDLE, push/pop 0, counts 0, idata=8'h01; a start started afterwards behaves as from reset.

Source files
------------

// File: rtl/xorexec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xorexec_pkg
// Description : Shared types and constants for the xorexec host traffic engine
//               (state encoding, LFSR taps, default seed, LFSR step helper).
// Revision    : 1.0 - initial release
// ============================================================================
package xorexec_pkg;

    // Run-control state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Feedback taps at bits 7, 5, 4 and 3
    localparam logic [7:0] c_lfsr_taps    = 8'hB8;

    // A zero seed would lock the LFSR, so it is replaced by this value
    localparam logic [7:0] c_default_seed = 8'h01;

    // One shift step: shift left, feedback into bit 0
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & c_lfsr_taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xorexec_host_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : 8-bit Fibonacci LFSR with synchronous load and advance enable.
//               A zero load value is substituted by the default seed.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
    import xorexec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_adv,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    // Load has priority over advance; reset returns to the default seed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_default_seed;
        end else if (i_load) begin
            r_state <= (i_seed == 8'd0) ? c_default_seed : i_seed;
        end else if (i_adv) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/xorexec_host.sv
`default_nettype none
// ============================================================================
// Module      : xorexec_host
// Description : Host-side traffic engine. Pushes an LFSR byte stream of
//               programmable length into the input FIFO, drains the output
//               FIFO, accumulates XOR signatures/counts on both streams and
//               flags a receive stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module xorexec_host
    import xorexec_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 64
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic [7:0]        seed,
    output logic              ififo_push,
    input  logic              ififo_not_full,
    output logic [DWIDTH-1:0] idata,
    output logic              ofifo_pop,
    input  logic              ofifo_rdy,
    input  logic [DWIDTH-1:0] odata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        tx_count,
    output logic [7:0]        rx_count,
    output logic [DWIDTH-1:0] tx_xor,
    output logic [DWIDTH-1:0] rx_xor
);

    localparam int                  c_to_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_to_w-1:0]   c_to_last = c_to_w'(TIMEOUT - 1);

    state_t              r_state;
    logic [7:0]          r_len;
    logic [7:0]          r_tx_count;
    logic [7:0]          r_rx_count;
    logic [DWIDTH-1:0]   r_tx_xor;
    logic [DWIDTH-1:0]   r_rx_xor;
    logic                r_err;
    logic                r_busy;
    logic                r_done;
    logic [c_to_w-1:0]   r_to_cnt;

    logic                w_push;
    logic                w_pop;
    logic                w_load;
    logic [7:0]          w_lfsr;
    logic                w_all_done;

    // FIFO handshakes are combinational so a ready FIFO is serviced every cycle
    assign w_push     = (r_state == RUN) && ififo_not_full && (r_tx_count < r_len);
    assign w_pop      = (r_state == RUN) && ofifo_rdy      && (r_rx_count < r_len);
    assign w_load     = (r_state == IDLE) && start && (len != 8'd0);
    // Completion is judged on registered counts, so FIN trails the last pop
    assign w_all_done = (r_tx_count == r_len) && (r_rx_count == r_len);

    lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_seed  (seed),
        .i_adv   (w_push),
        .o_state (w_lfsr)
    );

    // Run control, counters, signatures and stall timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= 8'd0;
            r_tx_count <= 8'd0;
            r_rx_count <= 8'd0;
            r_tx_xor   <= '0;
            r_rx_xor   <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len      <= len;
                        r_tx_count <= 8'd0;
                        r_rx_count <= 8'd0;
                        r_tx_xor   <= '0;
                        r_rx_xor   <= '0;
                        r_err      <= 1'b0;
                        r_to_cnt   <= '0;
                        if (len != 8'd0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (w_push) begin
                        r_tx_count <= r_tx_count + 8'd1;
                        r_tx_xor   <= r_tx_xor ^ idata;
                    end
                    if (w_pop) begin
                        r_rx_count <= r_rx_count + 8'd1;
                        r_rx_xor   <= r_rx_xor ^ odata;
                    end

                    if (w_all_done) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_pop) begin
                        r_to_cnt <= '0;
                    end else if (r_rx_count < r_len) begin
                        if (r_to_cnt == c_to_last) begin
                            r_err   <= 1'b1;
                            r_state <= FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end

                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ififo_push = w_push;
    assign ofifo_pop  = w_pop;
    assign idata      = DWIDTH'(w_lfsr);
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign tx_count   = r_tx_count;
    assign rx_count   = r_rx_count;
    assign tx_xor     = r_tx_xor;
    assign rx_xor     = r_rx_xor;

endmodule
`default_nettype wire

// File: tb/tb_xorexec_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_xorexec_host
// Description : Self-checking bench for xorexec_host with an output FIFO
//               looped back from the input FIFO and a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xorexec_host;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst, start, ififo_push, ififo_not_full, ofifo_pop, ofifo_rdy;
    logic       busy, done, err;
    logic [7:0] len, seed, idata, odata, tx_count, rx_count, tx_xor, rx_xor;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] g_pushed[$];

    xorexec_host #(.DWIDTH(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .seed(seed),
        .ififo_push(ififo_push), .ififo_not_full(ififo_not_full), .idata(idata),
        .ofifo_pop(ofifo_pop), .ofifo_rdy(ofifo_rdy), .odata(odata),
        .busy(busy), .done(done), .err(err),
        .tx_count(tx_count), .rx_count(rx_count), .tx_xor(tx_xor), .rx_xor(rx_xor)
    );

    always #5 clk = ~clk;

    // Polynomial from the stream definition: x' = {x[6:0], x7^x5^x4^x3}
    function automatic logic [7:0] model_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = 8'd0; seed = 8'd0;
        ififo_not_full = 1'b1; ofifo_rdy = 1'b1; odata = 8'hA5;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        n_tests++; if (ififo_push !== 1'b0) begin n_fail++; $display("FAIL reset_push got %b want 0", ififo_push); end
        n_tests++; if (ofifo_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop got %b want 0", ofifo_pop); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_tests++; if (idata !== 8'h01) begin n_fail++; $display("FAIL reset_idata got %h want 01", idata); end
        n_tests++; if ({tx_count, rx_count, tx_xor, rx_xor} !== 32'd0) begin n_fail++;
            $display("FAIL reset_counts got %h want 0", {tx_count, rx_count, tx_xor, rx_xor}); end
    endtask

    // mode: 0 always ready, 1 not_full low on run cycles 2-4, 2 rdy held low, 3 random
    task automatic do_run(input logic [7:0] l, input logic [7:0] s, input int mode,
                          output int run_cycles);
        logic [7:0] exp_byte, m_tx, m_rx, m_txx, m_rxx, b;
        logic [7:0] q[$];
        logic       nf, rdy_en, exp_push, exp_pop, exp_err, in_run, finished;
        int         nopop, c;
        exp_byte = (s == 8'd0) ? 8'h01 : s;
        m_tx = 0; m_rx = 0; m_txx = 0; m_rxx = 0; nopop = 0; c = 0;
        exp_err = 0; finished = 0; run_cycles = 0;
        g_pushed.delete();
        @(posedge clk); #1;
        start = 1'b1; len = l; seed = s; ififo_not_full = 1'b0; ofifo_rdy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; len = $urandom; seed = $urandom;
        in_run = (l != 8'd0);
        while (!finished && c < 3000) begin
            c++;
            if (in_run) begin
                run_cycles++;
                case (mode)
                    0: begin nf = 1; rdy_en = 1; end
                    1: begin nf = !(run_cycles >= 2 && run_cycles <= 4); rdy_en = 1; end
                    2: begin nf = 1; rdy_en = 0; end
                    default: begin nf = ($urandom_range(0, 3) != 0); rdy_en = ($urandom_range(0, 3) != 0); end
                endcase
                ififo_not_full = nf;
                ofifo_rdy = rdy_en && (q.size() > 0);
                odata = (q.size() > 0) ? q[0] : 8'($urandom);
                @(negedge clk);
                exp_push = nf && (m_tx < l);
                exp_pop  = ofifo_rdy && (m_rx < l);
                n_tests++; if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin n_fail++;
                    $display("FAIL run_flags cyc %0d got busy=%b done=%b err=%b want 1 0 0", run_cycles, busy, done, err); end
                n_tests++; if (ififo_push !== exp_push) begin n_fail++;
                    $display("FAIL run_push cyc %0d got %b want %b", run_cycles, ififo_push, exp_push); end
                n_tests++; if (ofifo_pop !== exp_pop) begin n_fail++;
                    $display("FAIL run_pop cyc %0d got %b want %b", run_cycles, ofifo_pop, exp_pop); end
                if (exp_push) begin
                    n_tests++; if (idata !== exp_byte) begin n_fail++;
                        $display("FAIL run_idata byte %0d got %h want %h", m_tx, idata, exp_byte); end
                end
                if (m_tx == l && m_rx == l) begin
                    in_run = 0;
                end else begin
                    if (exp_pop) begin
                        b = q.pop_front(); m_rxx ^= b; m_rx++; nopop = 0;
                    end else if (m_rx < l) begin
                        nopop++;
                        if (nopop == TO) begin exp_err = 1; in_run = 0; end
                    end
                    if (exp_push) begin
                        g_pushed.push_back(idata);
                        q.push_back(exp_byte); m_txx ^= exp_byte; m_tx++;
                        exp_byte = model_next(exp_byte);
                    end
                end
                @(posedge clk); #1;
            end else begin
                ififo_not_full = 1'b1; ofifo_rdy = 1'b1; odata = 8'($urandom);
                @(negedge clk);
                n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++;
                    $display("FAIL fin_flags got done=%b busy=%b want 1 0", done, busy); end
                n_tests++; if (ififo_push !== 1'b0 || ofifo_pop !== 1'b0) begin n_fail++;
                    $display("FAIL fin_idle_fifo got push=%b pop=%b want 0 0", ififo_push, ofifo_pop); end
                n_tests++; if (err !== exp_err) begin n_fail++;
                    $display("FAIL fin_err got %b want %b", err, exp_err); end
                n_tests++; if (tx_count !== m_tx || rx_count !== m_rx) begin n_fail++;
                    $display("FAIL fin_counts got %0d/%0d want %0d/%0d", tx_count, rx_count, m_tx, m_rx); end
                n_tests++; if (tx_xor !== m_txx || rx_xor !== m_rxx) begin n_fail++;
                    $display("FAIL fin_xor got %h/%h want %h/%h", tx_xor, rx_xor, m_txx, m_rxx); end
                @(posedge clk); #1;
                @(negedge clk);
                n_tests++; if (done !== 1'b0 || busy !== 1'b0 || ififo_push !== 1'b0) begin n_fail++;
                    $display("FAIL idle_after got done=%b busy=%b push=%b want 0 0 0", done, busy, ififo_push); end
                n_tests++; if (err !== exp_err || tx_count !== m_tx) begin n_fail++;
                    $display("FAIL idle_hold got err=%b tx=%0d want %b %0d", err, tx_count, exp_err, m_tx); end
                finished = 1;
                @(posedge clk); #1;
            end
        end
        if (!finished) begin
            n_tests++; n_fail++;
            $display("FAIL run_budget expired got unfinished want finished");
        end
    endtask

    task automatic test_loopback();
        int n;
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04; exp_seq[3] = 8'h08;
        do_run(8'd4, 8'h01, 0, n);
        n_tests++; if (g_pushed.size() != 4) begin n_fail++;
            $display("FAIL loop_npush got %0d want 4", g_pushed.size()); end
        for (int i = 0; i < 4 && i < g_pushed.size(); i++) begin
            n_tests++; if (g_pushed[i] !== exp_seq[i]) begin n_fail++;
                $display("FAIL loop_seq %0d got %h want %h", i, g_pushed[i], exp_seq[i]); end
        end
        n_tests++; if (tx_xor !== 8'h0F || rx_xor !== 8'h0F) begin n_fail++;
            $display("FAIL loop_xor got %h/%h want 0f/0f", tx_xor, rx_xor); end
    endtask

    task automatic test_not_full_gap();
        int n;
        do_run(8'd6, 8'h3C, 1, n);
    endtask

    task automatic test_zero_len();
        int n;
        do_run(8'd0, 8'h77, 0, n);
        n_tests++; if (n != 0 || g_pushed.size() != 0) begin n_fail++;
            $display("FAIL zero_len got run_cycles=%0d pushes=%0d want 0 0", n, g_pushed.size()); end
    endtask

    task automatic test_zero_seed();
        int n;
        do_run(8'd2, 8'h00, 0, n);
        n_tests++; if (g_pushed.size() != 2 || g_pushed[0] !== 8'h01 || g_pushed[1] !== 8'h02) begin n_fail++;
            $display("FAIL zero_seed got %0d bytes first %h want 01 02", g_pushed.size(),
                     (g_pushed.size() > 0) ? g_pushed[0] : 8'hxx); end
    endtask

    task automatic test_timeout();
        int n;
        do_run(8'd3, 8'h91, 2, n);
        n_tests++; if (n != 8) begin n_fail++; $display("FAIL timeout_cycles got %0d want 8", n); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", err); end
        // Next accepted start must clear the sticky error (checked inside the run)
        do_run(8'd1, 8'h42, 0, n);
    endtask

    task automatic test_reset_mid_run();
        int n;
        @(posedge clk); #1;
        start = 1'b1; len = 8'd10; seed = 8'h5A; ififo_not_full = 1'b1; ofifo_rdy = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (tx_count !== 8'd2) begin n_fail++; $display("FAIL midrst_pre got tx=%0d want 2", tx_count); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ofifo_rdy = 1'b1; odata = 8'h33;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || ififo_push !== 1'b0 || ofifo_pop !== 1'b0) begin n_fail++;
            $display("FAIL midrst_ctrl got busy=%b done=%b push=%b pop=%b want 0", busy, done, ififo_push, ofifo_pop); end
        n_tests++; if ({tx_count, rx_count, tx_xor, rx_xor} !== 32'd0 || idata !== 8'h01) begin n_fail++;
            $display("FAIL midrst_state got %h idata=%h want 0 01", {tx_count, rx_count, tx_xor, rx_xor}, idata); end
        do_run(8'd3, 8'h01, 0, n);
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 8; k++) begin
            do_run(8'($urandom_range(1, 40)), 8'($urandom), 3, n);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_not_full_gap();
        test_zero_len();
        test_zero_seed();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
